// File: rtl/iir_pkg.sv
// Shared types, shift constants and the saturate/wrap helper for the first-order IIR pair.
// Latency: none (package only).
// Backpressure: not applicable.
package iir_pkg;

   // History tracking: PRIME treats the previous sample as zero, RUN uses the stored one.
   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } hist_state_t;

   // Feedback taps: y>>>1 + y>>>2 gives the 0.75 pole.
   localparam int SHIFT_A = 1;
   localparam int SHIFT_B = 2;

   // Working width of the helper; callers sign-extend into it and slice back down.
   localparam int SW = 34;

   // Reduce a wide signed value to w+1 bits: wrap (modulo) or clamp to [-2^w, 2^w-1].
   // clipped is set only when clamping actually changed the value.
   function automatic logic signed [SW-1:0] sat_wrap(input logic signed [SW-1:0] v,
                                                     input int w,
                                                     input logic sat,
                                                     output logic clipped);
      logic signed [SW-1:0] one;
      logic signed [SW-1:0] hi;
      logic signed [SW-1:0] lo;
      logic signed [SW-1:0] r;
      one     = {{(SW-1){1'b0}}, 1'b1};
      hi      = (one <<< w) - one;
      lo      = -(one <<< w);
      r       = (v <<< (SW - 1 - w)) >>> (SW - 1 - w);
      clipped = 1'b0;
      if (sat) begin
         if (v > hi) begin
            r       = hi;
            clipped = 1'b1;
         end else if (v < lo) begin
            r       = lo;
            clipped = 1'b1;
         end else begin
            r       = v;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready pipeline register slot with synchronous flush.
// Latency: 1 cycle from load to vld.
// Backpressure: advances when empty or when the downstream stage advances; holds dat otherwise.
module pipe_stage #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          up_vld,
   input  logic [DW-1:0] up_dat,
   input  logic          dn_adv,
   output logic          adv,
   output logic          load,
   output logic          vld,
   output logic [DW-1:0] dat
);

   // Stage moves when it has nothing to hold or its content is being taken.
   always_comb begin
      adv  = ~vld | dn_adv;
      load = up_vld & adv;
   end

   // Occupancy and payload register; flush empties the slot but leaves the payload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld <= 1'b0;
         dat <= '0;
      end else if (flush) begin
         vld <= 1'b0;
      end else if (adv) begin
         vld <= up_vld;
         if (up_vld) begin
            dat <= up_dat;
         end
      end
   end

endmodule

// File: rtl/iir_inv.sv
// Inverse of y <= x + y>>>1 + y>>>2: x = y - y[n-1]>>>1 - y[n-1]>>>2; IIR_INV_SAT_EN selects clamp+ovf, else wrap.
// Latency: 2 cycles acceptance to out_valid (S1 difference register, S2 output register), 1 sample/cycle.
// Backpressure: valid/ready on both sides; out_ready=0 stalls S2 then S1; flush drops everything and blocks input.
module iir_inv
   import iir_pkg::*;
#(
   parameter int W = 14
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic signed [W:0]   y_in,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                flush,
   output logic signed [W:0]   x_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                ovf
);

`ifdef IIR_INV_SAT_EN
   localparam logic SAT_ON = 1'b1;
`else
   localparam logic SAT_ON = 1'b0;
`endif

   hist_state_t          state;
   hist_state_t          state_nxt;
   logic signed [W:0]    y_prev;
   logic signed [W:0]    hist;
   logic                 rdy_en;
   logic                 accept;

   logic signed [W+2:0]  y_ext;
   logic signed [W+2:0]  h_ext;
   logic signed [W+2:0]  diff_nxt;
   logic [W+2:0]         diff_q;
   logic signed [SW-1:0] sw_in;
   logic signed [SW-1:0] sw_out;
   logic                 clip;
   logic [SW-W-2:0]      ext_unused;
   logic [W:0]           x_nxt;
   logic [W:0]           x_q;

   logic                 s1_vld;
   logic                 s1_adv;
   logic                 s1_load_unused;
   logic                 s2_adv;
   logic                 s2_load;
   logic                 s2_vld;

   // Handshake gating: nothing enters during flush or before the first edge out of reset.
   always_comb begin
      in_ready  = rdy_en & s1_adv & ~flush;
      accept    = in_valid & in_ready;
      out_valid = s2_vld & ~flush;
      x_out     = x_q;
   end

   // in_ready is held low through reset and released on the first clock edge after it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
      end
   end

   // History state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= PRIME;
      end else begin
         state <= state_nxt;
      end
   end

   // History next state: flush re-primes, any acceptance moves to RUN.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = PRIME;
      end else if (accept) begin
         state_nxt = RUN;
      end
   end

   // Previous accepted sample; cleared by flush so PRIME restarts from zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         y_prev <= '0;
      end else if (flush) begin
         y_prev <= '0;
      end else if (accept) begin
         y_prev <= y_in;
      end
   end

   // Difference in W+3 bits so the 1.75x swing cannot overflow before the final reduction.
   always_comb begin
      hist     = (state == RUN) ? y_prev : '0;
      y_ext    = {{2{y_in[W]}}, y_in};
      h_ext    = {{2{hist[W]}}, hist};
      diff_nxt = y_ext - (h_ext >>> SHIFT_A) - (h_ext >>> SHIFT_B);
   end

   pipe_stage #(.DW(W + 3)) u_s1 (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .up_vld  (accept),
      .up_dat  (diff_nxt),
      .dn_adv  (s2_adv),
      .adv     (s1_adv),
      .load    (s1_load_unused),
      .vld     (s1_vld),
      .dat     (diff_q)
   );

   // Reduce the S1 difference to the output width (wrap or clamp).
   always_comb begin
      sw_in                = SW'($signed(diff_q));
      clip                 = 1'b0;
      sw_out               = sat_wrap(sw_in, W, SAT_ON, clip);
      {ext_unused, x_nxt}  = sw_out;
   end

   pipe_stage #(.DW(W + 1)) u_s2 (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .up_vld  (s1_vld),
      .up_dat  (x_nxt),
      .dn_adv  (out_ready),
      .adv     (s2_adv),
      .load    (s2_load),
      .vld     (s2_vld),
      .dat     (x_q)
   );

`ifdef IIR_INV_SAT_EN
   // Overflow pulse accompanies the S2 load of a clamped sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf <= 1'b0;
      end else if (flush) begin
         ovf <= 1'b0;
      end else begin
         ovf <= s2_load & clip;
      end
   end
`else
   logic clip_unused;
   logic s2_load_unused;
   // Wrap build never clips.
   always_comb begin
      ovf            = 1'b0;
      clip_unused    = clip;
      s2_load_unused = s2_load;
   end
`endif

endmodule
